char_ctl: RTL

CHAR_CTL -- requirements
Module: char_ctl

---
 rtl/char_ctl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/char_ctl.sv
// char_ctl: per-frame character motion controller.
// Buttons are synchronized, and the sprite moves once per frame on the rising edge of vsync.
// Horizontal movement is a fixed step, clamped to the screen edges so the sprite stays visible.
// Vertical motion is a ground/rise/fall jump with gravity, a ceiling clamp and a fall-speed cap.
// Ports:
//   clk, rst              system clock, synchronous active-high reset
//   vsync                 VGA vertical sync; each 0->1 transition is one frame tick
//   btn_left/right/jump   asynchronous player buttons, active-high
//   char_hgt, char_lng    sprite half-height / half-width from the draw stage
//   pos_x, pos_y          registered sprite centre coordinates
//   flip_h                registered facing direction, 1 = facing left
module char_ctl #(
  parameter int unsigned HOR_PIXELS = 800,
  parameter int unsigned X_INIT     = 160,
  parameter int unsigned GROUND_Y   = 524,
  parameter int unsigned MOVE_STEP  = 2,
  parameter int unsigned JUMP_V     = 12,
  parameter int unsigned GRAVITY    = 1,
  parameter int unsigned MAX_FALL   = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vsync,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_jump,
  input  logic [11:0] char_hgt,
  input  logic [11:0] char_lng,
  output logic [11:0] pos_x,
  output logic [11:0] pos_y,
  output logic        flip_h
);

  typedef enum logic [1:0] {StGround, StRise, StFall} state_e;

  state_e      state_q, state_d;
  logic [4:0]  vel_q, vel_d;
  logic [11:0] pos_x_q, pos_x_d;
  logic [11:0] pos_y_q, pos_y_d;
  logic        flip_q, flip_d;
  logic        jump_prev_q, jump_prev_d;

  // Bit order for both stages: {jump, right, left}.
  logic [2:0] btn_meta_q, btn_sync_q;
  logic       vsync_q, vsync_prev_q;

  logic tick, jump_edge, go_left, go_right;
  logic ceil_hit, floor_hit;
  logic [4:0]  rise_vel, fall_v;
  logic [5:0]  fall_sum;
  logic [11:0] right_lim;

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_meta_q   <= '0;
      btn_sync_q   <= '0;
      vsync_q      <= 1'b0;
      vsync_prev_q <= 1'b0;
    end else begin
      btn_meta_q   <= {btn_jump, btn_right, btn_left};
      btn_sync_q   <= btn_meta_q;
      vsync_q      <= vsync;
      vsync_prev_q <= vsync_q;
    end
  end

  // Edge taken between two registered copies, so the first cycle out of reset never ticks.
  assign tick      = vsync_q & ~vsync_prev_q;
  assign jump_edge = tick & btn_sync_q[2] & ~jump_prev_q;
  assign go_left   = btn_sync_q[0] & ~btn_sync_q[1];
  assign go_right  = btn_sync_q[1] & ~btn_sync_q[0];

  // Comparisons are done in 13 bits before any subtraction so nothing wraps below zero.
  assign rise_vel  = vel_q - 5'(GRAVITY);
  assign ceil_hit  = {1'b0, pos_y_q} < ({1'b0, char_hgt} + 13'(vel_q));
  assign fall_sum  = {1'b0, vel_q} + 6'(GRAVITY);
  assign fall_v    = (fall_sum > 6'(MAX_FALL)) ? 5'(MAX_FALL) : fall_sum[4:0];
  assign floor_hit = ({1'b0, pos_y_q} + 13'(fall_v)) >= 13'(GROUND_Y);
  assign right_lim = 12'(HOR_PIXELS - 1) - char_lng;

  // State register and motion registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StGround;
      vel_q       <= '0;
      pos_x_q     <= 12'(X_INIT);
      pos_y_q     <= 12'(GROUND_Y);
      flip_q      <= 1'b0;
      jump_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      vel_q       <= vel_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      flip_q      <= flip_d;
      jump_prev_q <= jump_prev_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (tick) begin
      case (state_q)
        StGround: if (jump_edge) state_d = StRise;
        StRise:   if (ceil_hit || rise_vel == 5'd0) state_d = StFall;
        StFall:   if (floor_hit) state_d = StGround;
        default:  state_d = StGround;
      endcase
    end
  end

  // Datapath: everything moves only on a frame tick.
  always_comb begin
    vel_d       = vel_q;
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    flip_d      = flip_q;
    jump_prev_d = jump_prev_q;
    if (tick) begin
      jump_prev_d = btn_sync_q[2];

      if (go_left) begin
        flip_d  = 1'b1;
        pos_x_d = ({1'b0, pos_x_q} < ({1'b0, char_lng} + 13'(MOVE_STEP))) ?
                  char_lng : pos_x_q - 12'(MOVE_STEP);
      end else if (go_right) begin
        flip_d  = 1'b0;
        pos_x_d = (({1'b0, pos_x_q} + 13'(MOVE_STEP)) > {1'b0, right_lim}) ?
                  right_lim : pos_x_q + 12'(MOVE_STEP);
      end

      case (state_q)
        StGround: if (jump_edge) vel_d = 5'(JUMP_V);
        StRise: begin
          if (ceil_hit) begin
            pos_y_d = char_hgt;
            vel_d   = '0;
          end else begin
            pos_y_d = pos_y_q - 12'(vel_q);
            vel_d   = rise_vel;
          end
        end
        StFall: begin
          if (floor_hit) begin
            pos_y_d = 12'(GROUND_Y);
            vel_d   = '0;
          end else begin
            pos_y_d = pos_y_q + 12'(fall_v);
            vel_d   = fall_v;
          end
        end
        default: vel_d = '0;
      endcase
    end
  end

  assign pos_x  = pos_x_q;
  assign pos_y  = pos_y_q;
  assign flip_h = flip_q;

endmodule
